// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding,
// the default operand width, and the divide-by-zero quotient value.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  localparam int unsigned DIV_WIDTH = 32;

  localparam logic [DIV_WIDTH-1:0] DIVZERO_QUOT = '1;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep it if non-negative.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             shift_in,
  input  logic [WIDTH:0]   divisor,
  output logic [WIDTH:0]   rem_o,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted = {rem_i, shift_in};
    // One extra guard bit so the borrow shows up as the sign of the difference.
    diff    = {1'b0, shifted} - {1'b0, divisor};
    q_bit   = ~diff[WIDTH+1];
    rem_o   = q_bit ? diff[WIDTH:0] : shifted;
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (div/divu) producing quotient on Lo and
// remainder on Hi. Define DIV_ABORT_EN to add the Abort input.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             SignedOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef DIV_ABORT_EN
  input  logic             Abort,
`endif
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Lo,
  output logic [WIDTH-1:0] Hi,
  output logic             DivByZero
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             dz_out_q, dz_out_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic             step_rem_msb_unused;
  logic             abort;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i    (rem_q),
    .shift_in (quo_q[WIDTH-1]),
    .divisor  (dvs_q),
    .rem_o    (step_rem),
    .q_bit    (step_q)
  );

  // The remainder never reaches the divisor, so the step's top bit is always 0.
  assign step_rem_msb_unused = step_rem[WIDTH];

`ifdef DIV_ABORT_EN
  assign abort = Abort;
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    a_raw_d  = a_raw_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    dz_d     = dz_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    dz_out_d = dz_out_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = CALC;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = (SignedOp && A[WIDTH-1]) ? -A : A;
          dvs_d   = {1'b0, ((SignedOp && B[WIDTH-1]) ? -B : B)};
          a_raw_d = A;
          q_neg_d = SignedOp & (A[WIDTH-1] ^ B[WIDTH-1]);
          r_neg_d = SignedOp & A[WIDTH-1];
          dz_d    = (B == '0);
        end
      end
      CALC: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], step_q};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d  = IDLE;
        done_d   = 1'b1;
        lo_d     = dz_q ? {WIDTH{DIVZERO_QUOT[0]}} : (q_neg_q ? -quo_q : quo_q);
        hi_d     = dz_q ? a_raw_q : (r_neg_q ? -rem_q : rem_q);
        dz_out_d = dz_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      a_raw_q  <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      dz_out_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      a_raw_q  <= a_raw_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      dz_q     <= dz_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      dz_out_q <= dz_out_d;
      done_q   <= done_d;
    end
  end

  assign Busy      = (state_q != IDLE);
  assign Done      = done_q;
  assign Lo        = lo_q;
  assign Hi        = hi_q;
  assign DivByZero = dz_out_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus random
// div/divu operations checked against plain-arithmetic expectations.
module tb_seq_divider;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic        SignedOp;
  logic [31:0] A;
  logic [31:0] B;
`ifdef DIV_ABORT_EN
  logic        Abort;
`endif
  logic        Busy;
  logic        Done;
  logic [31:0] Lo;
  logic [31:0] Hi;
  logic        DivByZero;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Start     (Start),
    .SignedOp  (SignedOp),
    .A         (A),
    .B         (B),
`ifdef DIV_ABORT_EN
    .Abort     (Abort),
`endif
    .Busy      (Busy),
    .Done      (Done),
    .Lo        (Lo),
    .Hi        (Hi),
    .DivByZero (DivByZero)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: plain SV arithmetic (signed / and % truncate toward zero).
  function automatic void model(input logic sg, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] lo, output logic [31:0] hi, output logic dz);
    longint sa, sb;
    if (b == 32'd0) begin
      lo = 32'hFFFF_FFFF;
      hi = a;
      dz = 1'b1;
    end else if (sg) begin
      sa = $signed(a);
      sb = $signed(b);
      lo = 32'(sa / sb);
      hi = 32'(sa % sb);
      dz = 1'b0;
    end else begin
      lo = a / b;
      hi = a % b;
      dz = 1'b0;
    end
  endfunction

  // Issues one operation at the next negedge and waits for Done. Returns at
  // #1 after the Done edge, so a following call issues during the Done cycle.
  task automatic do_op(input string tag, input logic sg, input logic [31:0] a,
                       input logic [31:0] b, input bit spam);
    logic [31:0] el, eh;
    logic        ez;
    int unsigned edges;
    bit          busy_ok;
    model(sg, a, b, el, eh, ez);
    @(negedge Clk);
    Start = 1'b1; SignedOp = sg; A = a; B = b;
    @(posedge Clk); #1;
    Start = 1'b0;
    edges   = 1;
    busy_ok = 1'b1;
    while (!Done && edges < 100) begin
      if (!Busy) busy_ok = 1'b0;
      if (spam && (edges == 5 || edges == 20)) begin
        Start = 1'b1; SignedOp = ~sg; A = $urandom; B = $urandom;
      end else begin
        Start = 1'b0;
      end
      @(posedge Clk); #1;
      edges++;
    end
    Start = 1'b0;
    check({tag, ".latency"}, 32'(edges), 32'd34);
    check({tag, ".busy_hold"}, 32'(busy_ok), 32'd1);
    check({tag, ".busy_at_done"}, 32'(Busy), 32'd0);
    check({tag, ".lo"}, Lo, el);
    check({tag, ".hi"}, Hi, eh);
    check({tag, ".dz"}, 32'(DivByZero), 32'(ez));
  endtask

  task automatic expect_idle_quiet(input string tag, input int unsigned cycles);
    int unsigned dones = 0;
    repeat (cycles) begin
      @(posedge Clk); #1;
      if (Done) dones++;
    end
    check({tag, ".no_done"}, 32'(dones), 32'd0);
    check({tag, ".idle"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    logic        sg;
    logic [31:0] ra, rb;

    Reset_n = 1'b0; Start = 1'b0; SignedOp = 1'b0; A = '0; B = '0;
`ifdef DIV_ABORT_EN
    Abort = 1'b0;
`endif
    #3;
    check("rst.busy", 32'(Busy), 32'd0);
    check("rst.done", 32'(Done), 32'd0);
    check("rst.lo", Lo, 32'd0);
    check("rst.hi", Hi, 32'd0);
    check("rst.dz", 32'(DivByZero), 32'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk) Reset_n = 1'b1;

    do_op("divu_100_7", 1'b0, 32'd100, 32'd7, 1'b0);
    do_op("div_m7_2", 1'b1, -32'sd7, 32'd2, 1'b0);
    do_op("div_7_m2", 1'b1, 32'd7, -32'sd2, 1'b0);
    do_op("div_m7_m2", 1'b1, -32'sd7, -32'sd2, 1'b0);
    do_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    do_op("div_by_zero", 1'b1, 32'h1234_5678, 32'd0, 1'b0);
    do_op("divu_by_zero", 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b0);
    do_op("start_ignored", 1'b0, 32'd1000, 32'd9, 1'b1);
    do_op("back_to_back", 1'b0, 32'd50, 32'd5, 1'b0);
    expect_idle_quiet("post_b2b", 3);

    // Reset after ten CALC steps must abort with every output cleared.
    @(negedge Clk);
    Start = 1'b1; SignedOp = 1'b0; A = 32'd12345; B = 32'd7;
    @(posedge Clk); #1 Start = 1'b0;
    repeat (10) @(posedge Clk);
    #1 Reset_n = 1'b0;
    #1;
    check("midrst.busy", 32'(Busy), 32'd0);
    check("midrst.done", 32'(Done), 32'd0);
    check("midrst.lo", Lo, 32'd0);
    check("midrst.hi", Hi, 32'd0);
    check("midrst.dz", 32'(DivByZero), 32'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk) Reset_n = 1'b1;
    expect_idle_quiet("after_rst", 40);
    do_op("after_rst_9_3", 1'b0, 32'd9, 32'd3, 1'b0);

`ifdef DIV_ABORT_EN
    do_op("pre_abort", 1'b0, 32'd100, 32'd7, 1'b0);
    @(negedge Clk);
    Start = 1'b1; SignedOp = 1'b0; A = 32'd999; B = 32'd4;
    @(posedge Clk); #1 Start = 1'b0;
    repeat (10) @(posedge Clk);
    #1 Abort = 1'b1;
    @(posedge Clk); #1 Abort = 1'b0;
    check("abort.busy", 32'(Busy), 32'd0);
    check("abort.done", 32'(Done), 32'd0);
    check("abort.lo", Lo, 32'd14);
    check("abort.hi", Hi, 32'd2);
    expect_idle_quiet("abort", 40);
`endif

    for (int i = 0; i < 24; i++) begin
      sg = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2:    rb = 32'($urandom_range(1, 15));
        3:       rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(1, 28);
      do_op($sformatf("rand%0d", i), sg, ra, rb, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle 32-bit integer divider for the MIPS datapath. Serves div/divu and writes the HI/LO pair.
- Complements the combinational ALU multiply path: the inverse operation, one quotient bit per cycle, restoring algorithm.
- Sits beside the ALU in EX. The control unit issues Start and stalls the pipeline while Busy is high.

Parameters:
- WIDTH, 32, operand/result width in bits (must be even, ≥4)
- CNT_W, 6, iteration counter width (must satisfy 2^CNT_W > WIDTH)

Ports:
- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous active-low reset
- Start  in  1  request; sampled only when Busy=0
- SignedOp  in  1  1=div (two's complement), 0=divu; sampled with Start
- A  in  WIDTH  dividend; sampled with Start
- B  in  WIDTH  divisor; sampled with Start
- Busy  out  1  operation in progress
- Done  out  1  one-cycle pulse, results valid
- Lo  out  WIDTH  quotient; held until next Done
- Hi  out  WIDTH  remainder; held until next Done
- DivByZero  out  1  divisor was 0; held with results

Behaviour:
- Reset (async, Reset_n=0): state IDLE; Busy=0, Done=0, Lo=0, Hi=0, DivByZero=0; counter and working registers cleared. Deassertion is taken on the next Clk edge.
- Reset asserted mid-operation aborts immediately; no Done is produced.
- States:
  - IDLE → CALC on the edge sampling Start=1. At that edge: latch operands; take magnitudes when SignedOp=1; record quotient sign = signA^signB and remainder sign = signA; clear the counter; Busy=1.
  - CALC: one restoring step per edge — shift {rem,quo} left 1, trial subtract |B|, keep it if non-negative, set the quotient LSB. The counter increments; after WIDTH steps go to FIX.
  - FIX (one edge): apply sign correction; load Lo/Hi/DivByZero; Done=1; Busy=0; return to IDLE.
- Latency: Done is high in the cycle after edge k+WIDTH+1, where k is the Start-sampling edge (34 edges for WIDTH=32). Busy is high from edge k until the Done edge. Done lasts exactly one cycle.
- Start while Busy=1 is ignored. Start in the same cycle Done is high is accepted (back-to-back issue; Busy rises at that edge).
- Signed rules: the quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Overflow case A=0x80000000, B=0xFFFFFFFF, signed: Lo=0x80000000, Hi=0.
  - Magnitudes are held in WIDTH+1 bits so |−2^31| is exact.
- Divide by zero (B=0, either mode): full latency; Lo=all ones, Hi=A (unmodified), DivByZero=1.
- Unsigned mode treats all bits as magnitude and applies no sign fix.
- Lo/Hi change only at the FIX edge or on reset.

Optional Feature:
- Macro: DIV_ABORT_EN.
- Defined: adds input port Abort (1 bit).
  - Abort=1 on an edge in CALC returns to IDLE with Busy=0 and no Done.
  - Lo/Hi/DivByZero keep their previous values.
  - Abort in IDLE or FIX has no effect.
  - Start and Abort in the same IDLE cycle: Start wins.
- Undefined: no Abort port; every accepted Start completes.

Decomposition:
- Shared package: state encoding (IDLE, CALC, FIX), DIV_WIDTH=32 default, and the DIVZERO_QUOT constant (all ones).
- One natural sub-module, div_step: combinational single restoring step (remainder in, divisor, next quotient bit out). It is unit-testable in isolation.
- Sign conditioning stays in the top-level block.

Test Plan:
- Unsigned: divu A=100, B=7 → Done exactly 34 edges after Start; Lo=14, Hi=2, DivByZero=0; Busy high throughout.
- Signed sign matrix, each operand pair issued with SignedOp=1:
  - −7/2 → Lo=−3, Hi=−1
  - 7/−2 → Lo=−3, Hi=1
  - −7/−2 → Lo=3, Hi=−1
- Boundary:
  - div 0x80000000 / 0xFFFFFFFF → Lo=0x80000000, Hi=0.
  - divu 0xFFFFFFFF / 1 → Lo=0xFFFFFFFF, Hi=0.
- Divide by zero: div A=0x12345678, B=0 → Lo=0xFFFFFFFF, Hi=0x12345678, DivByZero=1.
- Handshake: Start pulsed again at cycles 5 and 20 of an operation → ignored, with the results of the first operation unchanged. Start asserted during the Done cycle with 50/5 → second Done 34 edges later, Lo=10, Hi=0.
- Reset mid-op: Reset_n low at step 10 → all outputs 0 immediately, no Done. After release, 9/3 → Lo=3, Hi=0. With DIV_ABORT_EN: Abort at step 10 → Busy=0 next edge, Lo/Hi keep their prior values.
